// File: rtl/mem_ifc_pkg.sv
// Shared types and sizing helpers for the SDRAM read burst master.
package mem_ifc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    function automatic int word_bytes(input int data_width);
        return data_width / 8;
    endfunction

    // Width able to hold the value MAX_BURST itself, not just MAX_BURST-1.
    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/mem_read_fifo.sv
// Show-ahead read-data FIFO: the head word is visible on rd_data whenever
// empty is low; a write at edge N is readable right after edge N.
module mem_read_fifo
    import mem_ifc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_rd;
    logic                  do_wr;

    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    // A write into a full FIFO is only legal when a pop frees a slot the same cycle.
    assign do_wr   = wr_en && ((count != (PW+1)'(DEPTH)) || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mem_read_burst_master.sv
// Reads control_length bytes from control_base over an Avalon-MM burst master
// into a show-ahead FIFO. Bursting is enabled by defining MEM_READ_BURST_EN.
module mem_read_burst_master
    import mem_ifc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 26,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ADDR_WIDTH-1:0]             control_base,
    input  logic [ADDR_WIDTH-1:0]             control_length,
    input  logic                              control_go,
    output logic                              control_done,
    input  logic                              user_re,
    output logic [DATA_WIDTH-1:0]             user_data,
    output logic                              user_available,
    output logic [ADDR_WIDTH-1:0]             avm_address,
    output logic                              avm_read,
    output logic [burst_cnt_w(MAX_BURST)-1:0] avm_burstcount,
    input  logic                              avm_waitrequest,
    input  logic [DATA_WIDTH-1:0]             avm_readdata,
    input  logic                              avm_readdatavalid
);

    localparam int WB  = word_bytes(DATA_WIDTH);
    localparam int BCW = burst_cnt_w(MAX_BURST);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
`ifdef MEM_READ_BURST_EN
    localparam int EFF_BURST = MAX_BURST;
`else
    localparam int EFF_BURST = 1;
`endif
    localparam logic [ADDR_WIDTH-1:0] EFF_BURST_A = ADDR_WIDTH'(EFF_BURST);
    localparam logic [ADDR_WIDTH-1:0] WB_A        = ADDR_WIDTH'(WB);

    rd_state_e             state_q;
    rd_state_e             state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] words_left_q;
    logic [ADDR_WIDTH-1:0] go_words;
    logic [ADDR_WIDTH-1:0] burst_len;
    logic [ADDR_WIDTH-1:0] bc_ext;
    logic [CW-1:0]         outst_q;
    logic [CW-1:0]         outst_d;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           credit;
    logic                  rd_q;
    logic [BCW-1:0]        bc_q;
    logic                  done_q;
    logic                  done_set;
    logic                  accept;
    logic                  push;
    logic                  can_issue;
    logic                  fifo_empty;

    assign go_words  = control_length / WB_A;
    assign burst_len = (words_left_q < EFF_BURST_A) ? words_left_q : EFF_BURST_A;
    assign bc_ext    = ADDR_WIDTH'(bc_q);

    // Slots not yet claimed by data sitting in the FIFO or still in flight.
    assign credit    = (CW+1)'(FIFO_DEPTH) - {1'b0, fifo_count} - {1'b0, outst_q};
    assign can_issue = (state_q == ST_ISSUE) && !rd_q && (words_left_q != '0) &&
                       ({{ADDR_WIDTH{1'b0}}, credit} >= {{(CW+1){1'b0}}, burst_len});
    assign accept    = rd_q && !avm_waitrequest;
    // Data with nothing outstanding (e.g. stale beats after a reset) is dropped.
    assign push      = avm_readdatavalid && ((outst_q != '0) || accept);
    assign outst_d   = outst_q + (accept ? CW'(bc_q) : CW'(0)) - (push ? CW'(1) : CW'(0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        done_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (control_go) begin
                    if (go_words == '0) done_set = 1'b1;
                    else                state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (accept && (words_left_q == bc_ext)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((outst_q == '0) && fifo_empty) begin
                    done_set = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The request registers only change on issue or accept, so they stay
    // frozen for as long as the slave holds waitrequest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            words_left_q <= '0;
            outst_q      <= '0;
            rd_q         <= 1'b0;
            bc_q         <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q  <= done_set;
            outst_q <= outst_d;
            if ((state_q == ST_IDLE) && control_go) begin
                addr_q       <= control_base;
                words_left_q <= go_words;
            end
            if (can_issue) begin
                rd_q <= 1'b1;
                bc_q <= BCW'(burst_len);
            end
            if (accept) begin
                rd_q         <= 1'b0;
                addr_q       <= addr_q + bc_ext * WB_A;
                words_left_q <= words_left_q - bc_ext;
            end
        end
    end

    assign control_done   = done_q;
    assign avm_read       = rd_q;
    assign avm_address    = addr_q;
    assign avm_burstcount = bc_q;
    assign user_available = !fifo_empty;

    mem_read_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (avm_readdata),
        .rd_en   (user_re),
        .rd_data (user_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_mem_read_burst_master.sv
// Randomized scoreboard bench for mem_read_burst_master with a behavioural
// SDRAM slave; expected bursts and data come from byte/word arithmetic.
module tb_mem_read_burst_master;

    localparam int DW    = 32;
    localparam int AW    = 26;
    localparam int DEPTH = 16;
    localparam int MB    = 8;
`ifdef MEM_READ_BURST_EN
    localparam int EFF_MAX = MB;
`else
    localparam int EFF_MAX = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] control_base;
    logic [AW-1:0] control_length;
    logic          control_go;
    logic          control_done;
    logic          user_re;
    logic [DW-1:0] user_data;
    logic          user_available;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic [3:0]    avm_burstcount;
    logic          avm_waitrequest;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;

    mem_read_burst_master #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FIFO_DEPTH (DEPTH), .MAX_BURST (MB)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .control_base (control_base), .control_length (control_length),
        .control_go (control_go), .control_done (control_done),
        .user_re (user_re), .user_data (user_data), .user_available (user_available),
        .avm_address (avm_address), .avm_read (avm_read), .avm_burstcount (avm_burstcount),
        .avm_waitrequest (avm_waitrequest), .avm_readdata (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] eb_addr[$];
    int            eb_len[$];
    logic [AW-1:0] ret_q[$];

    int acc_words = 0, ret_words = 0, pop_words = 0;
    int done_cnt = 0, d_before = 0;
    int pop_pct = 100, wait_pct = 0, valid_pct = 100;
    bit force_wait = 1'b0, inject_stray = 1'b0, held_valid = 1'b0;
    logic [AW-1:0] held_addr;
    logic [3:0]    held_bc;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {a, 6'h15} ^ 32'h3C96_A55A;
    endfunction

    // Environment: user-side monitor and SDRAM slave, all at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            user_re           = 1'b0;
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
            held_valid        = 1'b0;
        end else begin
            int occ, outst, credit;
            occ    = ret_words - pop_words;
            outst  = acc_words - ret_words;
            credit = DEPTH - occ - outst;
            if (control_done) begin
                done_cnt++;
                check("done_data_drained", exp_q.size(), 0);
                check("done_bursts_issued", eb_addr.size(), 0);
            end
            check("available", user_available, occ != 0);
            user_re = 1'b0;
            if (user_available && $urandom_range(99) < pop_pct) begin
                if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
                else                   check("data", user_data, exp_q.pop_front());
                user_re = 1'b1;
                pop_words++;
            end
            if (held_valid)
                check("hold_stable", {avm_read, avm_address, avm_burstcount},
                      {1'b1, held_addr, held_bc});
            held_valid      = 1'b0;
            avm_waitrequest = force_wait || (wait_pct != 0 && $urandom_range(99) < wait_pct);
            if (avm_read) begin
                if (avm_waitrequest) begin
                    held_valid = 1'b1;
                    held_addr  = avm_address;
                    held_bc    = avm_burstcount;
                end else begin
                    if (eb_addr.size() == 0) check("burst_unexpected", 1, 0);
                    else begin
                        check("burst_addr", avm_address, eb_addr.pop_front());
                        check("burst_len", avm_burstcount, eb_len.pop_front());
                    end
                    check("burst_credit", credit >= int'(avm_burstcount), 1);
                    for (int k = 0; k < int'(avm_burstcount); k++)
                        ret_q.push_back(avm_address + AW'(4 * k));
                    acc_words += int'(avm_burstcount);
                end
            end
            avm_readdatavalid = 1'b0;
            if (inject_stray) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = 32'hDEAD_BEEF;
                inject_stray      = 1'b0;
            end else if (ret_q.size() != 0 && $urandom_range(99) < valid_pct) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = memf(ret_q.pop_front());
                ret_words++;
            end
        end
    end

    // Expected data and burst plan straight from base/length arithmetic.
    task automatic start_xfer(input logic [AW-1:0] base, input int nw);
        int            left;
        logic [AW-1:0] a;
        d_before = done_cnt;
        for (int i = 0; i < nw; i++) exp_q.push_back(memf(base + AW'(4 * i)));
        left = nw;
        a    = base;
        while (left > 0) begin
            int len;
            len = (left < EFF_MAX) ? left : EFF_MAX;
            eb_addr.push_back(a);
            eb_len.push_back(len);
            a    = a + AW'(len * 4);
            left = left - len;
        end
        @(negedge clk);
        control_base   = base;
        control_length = AW'(nw * 4);
        control_go     = 1'b1;
        @(negedge clk);
        control_go     = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (done_cnt == d_before && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({nm, "_done"}, done_cnt, d_before + 1);
        repeat (3) @(negedge clk);
        #1;
        check({nm, "_single_done"}, done_cnt, d_before + 1);
        check({nm, "_all_popped"}, exp_q.size(), 0);
    endtask

    task automatic clear_model();
        exp_q.delete(); eb_addr.delete(); eb_len.delete(); ret_q.delete();
        acc_words = 0; ret_words = 0; pop_words = 0;
        held_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        rst_n = 1'b0; control_go = 1'b0; control_base = '0; control_length = '0;
        user_re = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        #3;
        check("rst_done", control_done, 0);
        check("rst_read", avm_read, 0);
        check("rst_avail", user_available, 0);
        check("rst_addr", avm_address, 0);
        check("rst_bc", avm_burstcount, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // 16 words from 0x100, no stalls
        start_xfer(26'h100, 16);
        wait_done("basic", 500);

        // zero length: done one cycle after go, no reads
        a0 = acc_words;
        start_xfer(26'h40, 0);
        #1 check("zero_done_pulse", control_done, 1);
        @(negedge clk); #1;
        check("zero_done_clear", control_done, 0);
        check("zero_done_cnt", done_cnt, d_before + 1);
        repeat (5) @(negedge clk);
        check("zero_no_read", acc_words, a0);

        // 12 words: 8 then 4 when bursting
        pop_pct = 60; wait_pct = 20; valid_pct = 70;
        start_xfer(26'h2000, 12);
        wait_done("len12", 1000);

        // back-pressure: FIFO fills, issuing pauses, resumes on pops
        pop_pct = 0; wait_pct = 0; valid_pct = 100;
        start_xfer(26'h4000, 32);
        repeat (60) @(negedge clk);
        #1;
        check("bp_accepted", acc_words - a0, DEPTH + 12);
        check("bp_fifo_full", ret_words - pop_words, DEPTH);
        pop_pct = 100;
        wait_done("backpressure", 1000);

        // held waitrequest, plus a go that must be ignored mid-transfer
        force_wait = 1'b1;
        start_xfer(26'h400, 20);
        repeat (7) @(negedge clk);
        control_base = 26'h3000; control_length = 26'd32; control_go = 1'b1;
        @(negedge clk);
        control_go = 1'b0;
        force_wait = 1'b0;
        wait_done("stall", 1000);

        // reset mid-burst
        pop_pct = 50; wait_pct = 20; valid_pct = 80;
        start_xfer(26'h8000, 40);
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_done", control_done, 0);
        check("mid_rst_read", avm_read, 0);
        check("mid_rst_avail", user_available, 0);
        check("mid_rst_addr", avm_address, 0);
        check("mid_rst_bc", avm_burstcount, 0);
        clear_model();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        inject_stray = 1'b1;
        repeat (4) @(negedge clk);
        #1 check("stray_dropped", user_available, 0);
        start_xfer(26'h9000, 10);
        wait_done("after_reset", 1000);

        // randomized transfers, one wrapping past the top of the address space
        for (int t = 0; t < 10; t++) begin
            logic [AW-1:0] base;
            int            nw;
            base      = (t == 3) ? 26'h3FF_FFF0 : (AW'($urandom) & 26'h3FF_FFFC);
            nw        = $urandom_range(40);
            pop_pct   = $urandom_range(100, 20);
            wait_pct  = $urandom_range(40);
            valid_pct = $urandom_range(100, 40);
            start_xfer(base, nw);
            wait_done("random", 3000);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_read_burst_master.md
MEM_READ_BURST_MASTER -- requirements
Module: mem_read_burst_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, user/SDRAM data word width in bits; multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 26, byte address and length width.
REQ-003 Parameter FIFO_DEPTH, default 16, read-data buffer depth in words; power of 2, >=2.
REQ-004 Parameter MAX_BURST, default 8, max words per SDRAM read burst; 1..FIFO_DEPTH.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 control_base  in  ADDR_WIDTH  start byte address, word aligned.
REQ-009 control_length  in  ADDR_WIDTH  transfer length in bytes, multiple of DATA_WIDTH/8.
REQ-010 control_go  in  1  start pulse.
REQ-011 control_done  out  1  one-cycle completion pulse.
REQ-012 user_re  in  1  pop FIFO head.
REQ-013 user_data  out  DATA_WIDTH  FIFO head word (show-ahead).
REQ-014 user_available  out  1  FIFO non-empty.
REQ-015 avm_address  out  ADDR_WIDTH  SDRAM byte address of burst.
REQ-016 avm_read  out  1  burst read request.
REQ-017 avm_burstcount  out  $clog2(MAX_BURST)+1  words in burst.
REQ-018 avm_waitrequest  in  1  slave stall; request held while high.
REQ-019 avm_readdata  in  DATA_WIDTH  returned word.
REQ-020 avm_readdatavalid  in  1  avm_readdata valid this cycle.

Function
REQ-021 FSM states IDLE, ISSUE, DRAIN; IDLE out of reset.
REQ-022 IDLE + control_go: latch base/length, words_left = length/(DATA_WIDTH/8); nonzero -> ISSUE; zero -> control_done next cycle, stay IDLE.
REQ-023 control_go outside IDLE is ignored; latched values unaffected.
REQ-024 ISSUE: burst len = min(words_left, MAX_BURST); avm_read asserted only when FIFO free slots minus outstanding words >= burst len.
REQ-025 avm_address, avm_read, avm_burstcount held stable while avm_waitrequest high; burst accepted on cycle with avm_read=1, avm_waitrequest=0.
REQ-026 On accept: address += len*(DATA_WIDTH/8), words_left -= len, outstanding += len; words_left reaching 0 -> DRAIN.
REQ-027 Each avm_readdatavalid writes avm_readdata into FIFO and decrements outstanding same cycle; never overflows by REQ-024.
REQ-028 Accept and readdatavalid in same cycle: outstanding updated by +len-1.
REQ-029 user_re with user_available pops one word; user_re with FIFO empty ignored; push and pop same cycle keep count unchanged.
REQ-030 Fall-through latency: word written at edge N appears on user_data with user_available=1 after edge N.
REQ-031 DRAIN: when outstanding=0 and FIFO empty, control_done=1 for one cycle, -> IDLE.
REQ-032 Address arithmetic wraps modulo 2^ADDR_WIDTH.

Reset
REQ-033 rst_n low asynchronously: IDLE, FIFO empty, counters 0, control_done/avm_read/user_available 0, avm_address/avm_burstcount 0.
REQ-034 Reset mid-transfer abandons it; readdatavalid in reset-released IDLE with outstanding=0 is dropped.

Configuration
REQ-035 Macro MEM_READ_BURST_EN defined: bursting per REQ-024..026.
REQ-036 MEM_READ_BURST_EN undefined: MAX_BURST treated as 1, avm_burstcount constant 1, single-word reads only; all other behaviour identical.

Structure
REQ-037 Package mem_ifc_pkg: FSM state enum, word-bytes function, burst-count width function.
REQ-038 Sub-module mem_read_fifo: synchronous show-ahead FIFO, DATA_WIDTH x FIFO_DEPTH, with count output.

Verification
REQ-039 base=0x100, length=64, no stalls, burst on -> bursts 8@0x100, 8@0x120; 16 words delivered in order; one control_done.
REQ-040 length=0 -> control_done exactly one cycle after go; avm_read never asserted.
REQ-041 length=12 words, MAX_BURST=8 -> burstcounts 8 then 4; address step 32 bytes.
REQ-042 user_re held low, length=128 -> no burst issued while free-minus-outstanding < 8; FIFO never exceeds 16; resumes on pops.
REQ-043 avm_waitrequest high 5 cycles -> address/read/burstcount constant throughout; second go mid-transfer ignored.
REQ-044 rst_n low mid-burst -> all outputs at reset values immediately; new go after release completes normally.
